leader_parser: RTL
==================

LEADER_PARSER -- requirements
Module: leader_parser

Interface
REQ-001 Parameters: DATA_WD 32 (stream word width); SHORT_REG_WD 16 (short field width); REG_WD 32 (register field width); LONG_REG_WD 64 (long field width).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 i_leader_flag  in  1  high for the whole leader transfer; low between leaders.
REQ-005 i_data_valid  in  1  qualifies iv_data; a word is accepted when i_leader_flag and i_data_valid are both high.
REQ-006 iv_data  in  DATA_WD  leader word stream, word 0 first.
REQ-007 o_leader_done  out  1  one-cycle pulse when a complete, error-free leader has been committed.
REQ-008 o_leader_err  out  1  one-cycle pulse on a detected leader fault.
REQ-009 ov_err_code  out  3  fault code, valid with o_leader_err and held until the next fault.
REQ-010 o_chunk_mode_active  out  1; ov_blockid  out  LONG_REG_WD; ov_timestamp  out  LONG_REG_WD; ov_pixel_format  out  REG_WD; ov_size_x, ov_size_y, ov_offset_x, ov_offset_y  out  SHORT_REG_WD each: fields of the last good leader.

Function
REQ-011 Word map by accepted-word index 0..12:
- 0: 0x4C563355
- 1: [31:16]=52, [15:0]=0
- 2/3: blockid lo/hi
- 4: [31]=0, [30]=chunk, [29:16]=0x0001, [15:0]=0
- 5/6: timestamp lo/hi
- 7: pixel format
- 8..11: size_x, size_y, offset_x, offset_y in [15:0], [31:16]=0
- 12: padding, content ignored.
REQ-012 FSM states: IDLE, RECV, TAIL, DRAIN. IDLE->RECV on the first accepted word. RECV->TAIL after word 12. RECV->DRAIN on any fault. TAIL or DRAIN->IDLE when i_leader_flag is low.
REQ-013 A 4-bit word counter shall increment only on accepted words and clear in IDLE. Stalls (i_data_valid low, flag high) shall hold all state.
REQ-014 Fields shall be captured into shadow registers and copied to the outputs only on commit, so the outputs always hold the last good leader.
REQ-015 Commit and o_leader_done shall occur the cycle after word 12 is accepted (latency 1).
REQ-016 Fault codes:
- 1: word 0 is not the magic value.
- 2: word 1 is not {16'd52,16'h0}.
- 3: word 4 with bit 30 masked is not 0x00010000.
- 4: short leader (i_leader_flag falls in RECV).
- 5: long leader (a valid word arrives in TAIL).
- 6: blockid mismatch (see Configuration).
REQ-017 Faults 1-3 and 6 shall be flagged the cycle after the offending word. Fault 4 shall be flagged the cycle after flag deassertion. No commit shall occur for faults 1-4 and 6.
REQ-018 Fault 5 shall not revoke an already committed leader, and shall pulse only once per leader.
REQ-019 If i_leader_flag falls in the same cycle that word 12 is accepted, the leader is complete: done pulses, no fault.
REQ-020 Only one o_leader_err pulse per leader; further faults in DRAIN shall be ignored.
REQ-021 After a fault or completion, a new leader shall be accepted only after i_leader_flag has been low for at least one cycle.

Reset
REQ-022 With reset low at a clock edge: FSM->IDLE; counter, shadow registers and all outputs->0, including ov_err_code=0 and both pulses low.
REQ-023 Reset mid-leader discards the partial leader with no done or err pulse. After reset releases, the parser waits for i_leader_flag low before accepting a leader.

Configuration
REQ-024 Macro LEADER_PARSER_BLOCKID_CHECK_EN.
- Defined: a blockid not equal to the previous committed blockid + 1 (64-bit wrap) shall raise fault 6. The first leader after reset is exempt.
- Undefined: no blockid check is done, and code 6 is never produced.

Verification
REQ-025 Good leader (blockid 5, ts 0x1_00000002, pixfmt 0x01080001, 640x480 at offset 8,4, chunk 1), words back-to-back -> done pulses 1 cycle after word 12; all outputs match; err stays low.
REQ-026 Same leader with i_data_valid low on alternate cycles -> identical outputs; done pulses 1 cycle after the last word.
REQ-027 Word 0 = 0x4C563356 -> err with code 1 in the next cycle; outputs keep previous values; no done; a following good leader commits.
REQ-028 Flag drops after 9 words -> err with code 4; flag drops on the same cycle as word 12 -> done, no err; 14 words -> done then err with code 5.
REQ-029 With macro defined: blockids 5, 6, 8 -> done, done, then err with code 6 and ov_blockid stays 6. Without macro: all three commit.
REQ-030 Reset low at word 7, then a good leader -> no pulse from the aborted leader; the next leader commits.

Source files
------------

// File: rtl/leader_parser.sv
// ---------------------------------------------------------------------------
// leader_parser
//
// Parses a 13-word leader from a 32-bit word stream. It validates the fixed
// fields, captures the variable fields into shadow registers, and copies them
// to the outputs only when a complete, error-free leader has been received.
// The outputs therefore always reflect the last good leader.
//
// Optional feature (compile-time macro):
//   LEADER_PARSER_BLOCKID_CHECK_EN
//       Defined   : every leader after the first committed one must carry
//                   blockid = previous committed blockid + 1 (64-bit wrap),
//                   otherwise fault code 6 is raised.
//       Undefined : no blockid continuity check; code 6 never occurs.
//
// Ports:
//   clk                  single clock, rising edge
//   reset                synchronous, active-low reset
//   i_leader_flag        high for the whole leader transfer
//   i_data_valid         qualifies iv_data (word accepted when flag & valid)
//   iv_data              leader word stream, word 0 first
//   o_leader_done        1-cycle pulse: good leader committed
//   o_leader_err         1-cycle pulse: leader fault detected
//   ov_err_code          fault code, held until the next fault
//   o_chunk_mode_active  chunk bit of the last good leader
//   ov_blockid           blockid of the last good leader
//   ov_timestamp         timestamp of the last good leader
//   ov_pixel_format      pixel format of the last good leader
//   ov_size_x/_y         image size of the last good leader
//   ov_offset_x/_y       image offset of the last good leader
// ---------------------------------------------------------------------------
module leader_parser #(
    parameter int DATA_WD      = 32,
    parameter int SHORT_REG_WD = 16,
    parameter int REG_WD       = 32,
    parameter int LONG_REG_WD  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_leader_flag,
    input  logic                    i_data_valid,
    input  logic [DATA_WD-1:0]      iv_data,
    output logic                    o_leader_done,
    output logic                    o_leader_err,
    output logic [2:0]              ov_err_code,
    output logic                    o_chunk_mode_active,
    output logic [LONG_REG_WD-1:0]  ov_blockid,
    output logic [LONG_REG_WD-1:0]  ov_timestamp,
    output logic [REG_WD-1:0]       ov_pixel_format,
    output logic [SHORT_REG_WD-1:0] ov_size_x,
    output logic [SHORT_REG_WD-1:0] ov_size_y,
    output logic [SHORT_REG_WD-1:0] ov_offset_x,
    output logic [SHORT_REG_WD-1:0] ov_offset_y
);

    localparam logic [DATA_WD-1:0] MAGIC_WORD = DATA_WD'(32'h4C56_3355);
    localparam logic [DATA_WD-1:0] WORD1_VAL  = DATA_WD'(32'h0034_0000);
    localparam logic [DATA_WD-1:0] WORD4_MASK = DATA_WD'(32'hBFFF_FFFF);
    localparam logic [DATA_WD-1:0] WORD4_VAL  = DATA_WD'(32'h0001_0000);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    // Set once the flag has been seen low; blocks a leader that was already
    // in flight when reset released from being picked up half-way through.
    logic                    armed_reg;

    // Shadow registers for the leader currently being received.
    logic [LONG_REG_WD-1:0]  blockid_sh_reg;
    logic [LONG_REG_WD-1:0]  timestamp_sh_reg;
    logic [REG_WD-1:0]       pixfmt_sh_reg;
    logic [SHORT_REG_WD-1:0] size_x_sh_reg;
    logic [SHORT_REG_WD-1:0] size_y_sh_reg;
    logic [SHORT_REG_WD-1:0] offset_x_sh_reg;
    logic [SHORT_REG_WD-1:0] offset_y_sh_reg;
    logic                    chunk_sh_reg;

    // Committed (output) registers.
    logic                    done_reg;
    logic                    err_reg;
    logic [2:0]              err_code_reg;
    logic                    chunk_reg;
    logic [LONG_REG_WD-1:0]  blockid_reg;
    logic [LONG_REG_WD-1:0]  timestamp_reg;
    logic [REG_WD-1:0]       pixfmt_reg;
    logic [SHORT_REG_WD-1:0] size_x_reg;
    logic [SHORT_REG_WD-1:0] size_y_reg;
    logic [SHORT_REG_WD-1:0] offset_x_reg;
    logic [SHORT_REG_WD-1:0] offset_y_reg;

`ifdef LEADER_PARSER_BLOCKID_CHECK_EN
    // The first leader after reset has no predecessor to compare against.
    logic                    have_commit_reg;
`endif

    logic       accept;
    logic       word_fault;
    logic [2:0] word_code;

    assign accept = i_leader_flag & i_data_valid;

    // Content check of the word currently on iv_data, indexed by cnt_reg.
    // cnt_reg is guaranteed 0 whenever the FSM sits in IDLE.
    always_comb begin
        word_fault = 1'b0;
        word_code  = 3'd0;
        case (cnt_reg)
            4'd0: begin
                if (iv_data != MAGIC_WORD) begin
                    word_fault = 1'b1;
                    word_code  = 3'd1;
                end
            end
            4'd1: begin
                if (iv_data != WORD1_VAL) begin
                    word_fault = 1'b1;
                    word_code  = 3'd2;
                end
            end
`ifdef LEADER_PARSER_BLOCKID_CHECK_EN
            4'd3: begin
                // Low half was captured on word 2; combine with the high half now.
                if (have_commit_reg &&
                    ({iv_data, blockid_sh_reg[DATA_WD-1:0]} !=
                     blockid_reg + LONG_REG_WD'(1))) begin
                    word_fault = 1'b1;
                    word_code  = 3'd6;
                end
            end
`endif
            4'd4: begin
                if ((iv_data & WORD4_MASK) != WORD4_VAL) begin
                    word_fault = 1'b1;
                    word_code  = 3'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            armed_reg        <= 1'b0;
            blockid_sh_reg   <= '0;
            timestamp_sh_reg <= '0;
            pixfmt_sh_reg    <= '0;
            size_x_sh_reg    <= '0;
            size_y_sh_reg    <= '0;
            offset_x_sh_reg  <= '0;
            offset_y_sh_reg  <= '0;
            chunk_sh_reg     <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            err_code_reg     <= 3'd0;
            chunk_reg        <= 1'b0;
            blockid_reg      <= '0;
            timestamp_reg    <= '0;
            pixfmt_reg       <= '0;
            size_x_reg       <= '0;
            size_y_reg       <= '0;
            offset_x_reg     <= '0;
            offset_y_reg     <= '0;
`ifdef LEADER_PARSER_BLOCKID_CHECK_EN
            have_commit_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            if (!i_leader_flag) begin
                armed_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    cnt_reg <= 4'd0;
                    if (accept && armed_reg) begin
                        if (word_fault) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= word_code;
                            state_reg    <= DRAIN;
                        end else begin
                            cnt_reg   <= 4'd1;
                            state_reg <= RECV;
                        end
                    end
                end

                RECV: begin
                    if (!i_leader_flag) begin
                        // Flag fell before word 12 was accepted: short leader.
                        err_reg      <= 1'b1;
                        err_code_reg <= 3'd4;
                        state_reg    <= DRAIN;
                    end else if (i_data_valid) begin
                        if (word_fault) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= word_code;
                            state_reg    <= DRAIN;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                            case (cnt_reg)
                                4'd2:  blockid_sh_reg[DATA_WD-1:0]             <= iv_data;
                                4'd3:  blockid_sh_reg[LONG_REG_WD-1:DATA_WD]   <= iv_data;
                                4'd4:  chunk_sh_reg                            <= iv_data[30];
                                4'd5:  timestamp_sh_reg[DATA_WD-1:0]           <= iv_data;
                                4'd6:  timestamp_sh_reg[LONG_REG_WD-1:DATA_WD] <= iv_data;
                                4'd7:  pixfmt_sh_reg   <= iv_data[REG_WD-1:0];
                                4'd8:  size_x_sh_reg   <= iv_data[SHORT_REG_WD-1:0];
                                4'd9:  size_y_sh_reg   <= iv_data[SHORT_REG_WD-1:0];
                                4'd10: offset_x_sh_reg <= iv_data[SHORT_REG_WD-1:0];
                                4'd11: offset_y_sh_reg <= iv_data[SHORT_REG_WD-1:0];
                                default: ;
                            endcase
                            if (cnt_reg == 4'd12) begin
                                // Word 12 is padding; all fields are already shadowed.
                                done_reg      <= 1'b1;
                                chunk_reg     <= chunk_sh_reg;
                                blockid_reg   <= blockid_sh_reg;
                                timestamp_reg <= timestamp_sh_reg;
                                pixfmt_reg    <= pixfmt_sh_reg;
                                size_x_reg    <= size_x_sh_reg;
                                size_y_reg    <= size_y_sh_reg;
                                offset_x_reg  <= offset_x_sh_reg;
                                offset_y_reg  <= offset_y_sh_reg;
`ifdef LEADER_PARSER_BLOCKID_CHECK_EN
                                have_commit_reg <= 1'b1;
`endif
                                state_reg     <= TAIL;
                            end
                        end
                    end
                end

                TAIL: begin
                    if (!i_leader_flag) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= IDLE;
                    end else if (i_data_valid) begin
                        // Extra word after a committed leader: report once,
                        // keep the committed fields.
                        err_reg      <= 1'b1;
                        err_code_reg <= 3'd5;
                        state_reg    <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (!i_leader_flag) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    cnt_reg   <= 4'd0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_leader_done       = done_reg;
    assign o_leader_err        = err_reg;
    assign ov_err_code         = err_code_reg;
    assign o_chunk_mode_active = chunk_reg;
    assign ov_blockid          = blockid_reg;
    assign ov_timestamp        = timestamp_reg;
    assign ov_pixel_format     = pixfmt_reg;
    assign ov_size_x           = size_x_reg;
    assign ov_size_y           = size_y_reg;
    assign ov_offset_x         = offset_x_reg;
    assign ov_offset_y         = offset_y_reg;

endmodule
